// File: rtl/hsv_core_issue_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : hsv_core_issue_dispatch
// Brief    : In-order issue dispatcher with register scoreboard and per-port FIFOs
// Revision : 1.0
// ============================================================================
module hsv_core_issue_dispatch #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_REGS   = 32,
  localparam int REG_W  = $clog2(NUM_REGS),
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk_core,
  input  logic                        rst_core,
  input  logic                        flush_req,
  output logic                        flush_ack,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [PORT_W-1:0]           in_port,
  input  logic [REG_W-1:0]            in_rs1,
  input  logic [REG_W-1:0]            in_rs2,
  input  logic [REG_W-1:0]            in_rd,
  input  logic                        in_rs1_used,
  input  logic                        in_rs2_used,
  input  logic                        in_rd_used,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS*CNT_W-1:0]  out_count,
  input  logic [NUM_REGS-1:0]         commit_mask,
  output logic                        err_bad_port
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [NUM_REGS-1:0]  eff_pending;
  logic [NUM_REGS-1:0]  set_vec;
  logic                 hazard;
  logic                 bad_port;
  logic                 sel_full;
  logic                 accept;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic                 err_bad_port_q, err_bad_port_d;
  logic                 flush_ack_q, flush_ack_d;

  always_comb begin
    // Commits retiring this cycle release their registers immediately.
    eff_pending = pending_q & ~commit_mask;
    hazard      = (in_rs1_used & eff_pending[in_rs1])
                | (in_rs2_used & eff_pending[in_rs2])
                | (in_rd_used  & eff_pending[in_rd]);
    bad_port    = ({1'b0, in_port} >= (PORT_W+1)'(NUM_PORTS));

    sel_full = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_port == PORT_W'(p)) sel_full = full[p];
    end

    ready_o = ~flush_req & ~hazard & (bad_port | ~sel_full);
    accept  = valid_i & ready_o;

    push = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p] = accept & ~bad_port & (in_port == PORT_W'(p));
    end

    set_vec = '0;
    if (accept && !bad_port && in_rd_used && (in_rd != '0)) set_vec[in_rd] = 1'b1;

    pending_d    = flush_req ? '0 : ((pending_q & ~commit_mask) | set_vec);
    pending_d[0] = 1'b0;

    err_bad_port_d = accept & bad_port;
    flush_ack_d    = flush_req;
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      pending_q      <= '0;
      err_bad_port_q <= 1'b0;
      flush_ack_q    <= 1'b1;
    end else begin
      pending_q      <= pending_d;
      err_bad_port_q <= err_bad_port_d;
      flush_ack_q    <= flush_ack_d;
    end
  end

  assign err_bad_port = err_bad_port_q;
  assign flush_ack    = flush_ack_q;

  generate
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]  count_q, count_d;

      assign full[gp]      = (count_q == CNT_W'(FIFO_DEPTH));
      assign out_valid[gp] = (count_q != '0);
      assign pop[gp]       = out_valid[gp] & out_ready[gp];
      assign out_data[gp*DATA_W +: DATA_W] = mem_q[rd_ptr_q];
      assign out_count[gp*CNT_W +: CNT_W]  = count_q;

      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push[gp]) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
          end
          if (pop[gp]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push[gp]) - CNT_W'(pop[gp]);
        end
      end

      always_ff @(posedge clk_core) begin
        if (rst_core) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Payload storage carries no reset; contents are only visible when valid.
      always_ff @(posedge clk_core) begin
        mem_q <= mem_d;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/hsv_core_issue_dispatch.md
# hsv_core_issue_dispatch

Parametrised in-order issue dispatcher for the hsv core. It accepts decoded instructions from decode and tracks RAW/WAW hazards with a register scoreboard cleared by commit feedback. Each instruction is routed to one of NUM_PORTS execution ports through a per-port FIFO of configurable depth. It generalises the fixed five-port, skid-depth-2 issue stage to any port count, payload width and buffer depth, and adds per-port occupancy reporting and bad-port error flagging.

## Interface
Parameters:
- NUM_PORTS, 5, number of execution ports (≥1)
- DATA_W, 64, payload width per instruction (≥1)
- FIFO_DEPTH, 2, entries per port FIFO (power of two, ≥2)
- NUM_REGS, 32, architectural registers (power of two); REG_W = $clog2(NUM_REGS), PORT_W = max(1,$clog2(NUM_PORTS)), CNT_W = $clog2(FIFO_DEPTH)+1

Ports:
- clk_core  in  1  core clock; all state updates on rising edge
- rst_core  in  1  reset, synchronous, active-high
- flush_req  in  1  pipeline flush request
- flush_ack  out  1  flush acknowledge
- in_data  in  DATA_W  instruction payload, passed through unmodified
- in_port  in  PORT_W  target execution port index
- in_rs1, in_rs2, in_rd  in  REG_W each  source/destination register indices
- in_rs1_used, in_rs2_used, in_rd_used  in  1 each  operand-use qualifiers
- valid_i  in  1  input valid
- ready_o  out  1  input ready
- out_data  out  NUM_PORTS*DATA_W  port p payload at bits [p*DATA_W +: DATA_W]
- out_valid  out  NUM_PORTS  per-port valid
- out_ready  in  NUM_PORTS  per-port ready
- out_count  out  NUM_PORTS*CNT_W  per-port FIFO occupancy
- commit_mask  in  NUM_REGS  registers whose pending write retires this cycle
- err_bad_port  out  1  pulse: accepted beat had in_port ≥ NUM_PORTS

## Operation
- Scoreboard: pending[NUM_REGS]. Bit 0 always 0.
- eff_pending = pending & ~commit_mask (same-cycle commit bypass).
- hazard = (in_rs1_used & eff_pending[in_rs1]) | (in_rs2_used & eff_pending[in_rs2]) | (in_rd_used & eff_pending[in_rd]). WAW stalls, as does RAW.
- Bad port (in_port ≥ NUM_PORTS): no FIFO write, no scoreboard set; hazard still applies.
- ready_o = ~flush_req & ~hazard & (bad port | ~full[in_port]). ready_o depends only on inputs and state, never on valid_i.
- Accept = valid_i & ready_o:
  - good port: push {in_data} into FIFO[in_port]; if in_rd_used & in_rd≠0, set pending[in_rd].
  - bad port: drop the beat; err_bad_port = 1 next cycle for one cycle.
- Pending update each cycle: pending <= (pending & ~commit_mask) | set_vec. A set wins over a same-cycle commit of the same register.
- Each FIFO is independent. Pop when out_valid[p] & out_ready[p]. Simultaneous push and pop on a full FIFO is not possible, because ready_o is low when full. Simultaneous push and pop on a non-full FIFO keeps the count. Pointers wrap modulo FIFO_DEPTH.
- out_valid[p] = count[p] ≠ 0. out_data[p] = head entry, registered storage.
- Flush: while flush_req is high, no accept occurs. On each flush_req cycle, all FIFOs are emptied (count 0, pointers 0), pending is cleared, and err_bad_port is cleared. flush_ack <= flush_req.

## Timing
- Reset (rst_core=1 at an edge) gives: all FIFOs empty, out_valid=0, out_count=0, pending=0, err_bad_port=0, flush_ack=1. The out_data value is don't-care.
- Reset mid-operation discards all in-flight entries with no drain.
- Latency: a beat accepted at edge N shows out_valid[p]=1 from N (visible the cycle after the accept cycle). Throughput is 1 beat/cycle.
- Hazard resolution: a dependent beat presented together with the commit_mask bit for its source is accepted in that same cycle.
- An out_ready change affects ready_o only through the next-cycle count. There is no combinational out_ready→ready_o path.
- Flush precedence: flush_req > accept; flush_req > pop (a pop in a flush cycle is irrelevant).
- Port p's out_valid must not drop without a pop or flush.

## Test plan
- Basic routing (NUM_PORTS=5, DEPTH=2): send 5 beats, in_port 0..4, data 0x10..0x14, all out_ready=1. Each out_valid[p] pulses one cycle with 0x1p; pending ends {rd bits} until commit.
- RAW stall: beat A rd=5, then beat B rs1=5. ready_o=0 for B until commit_mask[5]=1. B is accepted in the commit cycle, and pending[5] goes 0 in the next cycle.
- Backpressure/full: out_ready[2]=0, push 3 beats to port 2. The first 2 are accepted (out_count[2]=2) and the third holds ready_o=0. Raising out_ready[2] accepts the third the next cycle, and order is preserved.
- Set-vs-commit: commit_mask[7]=1 in the same cycle a beat with rd=7 is accepted. pending[7]=1 afterwards.
- Flush: fill ports 0 and 3, set pending {3,9}, assert flush_req for 1 cycle. ready_o=0 that cycle; next cycle out_valid=0, pending=0, flush_ack=1; one cycle later flush_ack=0.
- Bad port and x0: a beat with in_port=6 and rd=4 is accepted, err_bad_port pulses once, and no out_valid or pending[4] results. A beat with rd=0 never stalls its successor with rs1=0.
